// File: rtl/ej32_rstack.sv
// eJ32 return stack: register-file stack with cached top, overflow/underflow flags,
// single-cycle DNEXT and a two-cycle busy-handshaked indexed PICK read.
module ej32_rstack #(
  parameter  int DSZ   = 32,
  parameter  int DEPTH = 64,
  localparam int SSZ   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2:0]     op,
  input  logic [DSZ-1:0] din,
  input  logic [SSZ-1:0] idx,
  output logic [DSZ-1:0] r_o,
  output logic           rz_o,
  output logic [SSZ:0]   rp_o,
  output logic           full,
  output logic           empty,
  output logic           busy,
  output logic [DSZ-1:0] pick_o,
  output logic           pick_v,
  output logic           taken,
  output logic           ovf,
  output logic           udf
);

  localparam logic [2:0] OP_PUSH   = 3'd1;
  localparam logic [2:0] OP_POP    = 3'd2;
  localparam logic [2:0] OP_MOVE   = 3'd3;
  localparam logic [2:0] OP_PICK   = 3'd4;
  localparam logic [2:0] OP_DNEXT  = 3'd5;
  localparam logic [2:0] OP_CLRERR = 3'd6;
  localparam logic [SSZ:0] LP_DEPTH = (SSZ+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_PICK1} state_t;

  logic [DSZ-1:0] r_mem [DEPTH];
  logic [DSZ-1:0] r_top, r_pick_o;
  logic [SSZ:0]   r_rp;
  logic [SSZ-1:0] r_addr;
  logic           r_rz, r_busy, r_pick_v, r_taken, r_ovf, r_udf, r_bad;
  state_t         r_state;

  logic           w_acc, w_empty, w_full, w_we, w_do_pop;
  logic           w_ovf_set, w_udf_set, w_taken, w_clr;
  logic [SSZ-1:0] w_rpm1, w_rpm2, w_waddr;
  logic [DSZ-1:0] w_wdat, w_top_nxt, w_dec;
  logic [SSZ:0]   w_rp_nxt;

  assign w_acc   = en && (r_state == S_IDLE);
  assign w_clr   = en && (op == OP_CLRERR);
  assign w_empty = (r_rp == '0);
  assign w_full  = (r_rp == LP_DEPTH);
  // Low-bit arithmetic wraps correctly when rp == DEPTH (low bits are zero).
  assign w_rpm1  = r_rp[SSZ-1:0] - SSZ'(1);
  assign w_rpm2  = r_rp[SSZ-1:0] - SSZ'(2);
  assign w_dec   = r_top - DSZ'(1);

  always_comb begin
    w_top_nxt = r_top;
    w_rp_nxt  = r_rp;
    w_we      = 1'b0;
    w_waddr   = w_rpm1;
    w_wdat    = din;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    w_taken   = 1'b0;
    w_do_pop  = 1'b0;
    if (w_acc) begin
      case (op)
        OP_PUSH: begin
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_waddr   = r_rp[SSZ-1:0];
            w_top_nxt = din;
            w_rp_nxt  = r_rp + (SSZ+1)'(1);
          end
        end
        OP_POP: begin
          if (w_empty) w_udf_set = 1'b1;
          else         w_do_pop  = 1'b1;
        end
        OP_MOVE: begin
          if (w_empty) begin
            w_udf_set = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_top_nxt = din;
          end
        end
        OP_DNEXT: begin
          if (w_empty) begin
            w_udf_set = 1'b1;
          end else if (r_rz) begin
            w_do_pop = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_wdat    = w_dec;
            w_top_nxt = w_dec;
            w_taken   = 1'b1;
          end
        end
        OP_PICK: begin
          if ({1'b0, idx} >= r_rp) w_udf_set = 1'b1;
        end
        default: ;
      endcase
    end
    if (w_do_pop) begin
      w_rp_nxt  = r_rp - (SSZ+1)'(1);
      w_top_nxt = (r_rp == (SSZ+1)'(1)) ? '0 : r_mem[w_rpm2];
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rp     <= '0;
      r_top    <= '0;
      r_rz     <= 1'b1;
      r_busy   <= 1'b0;
      r_pick_o <= '0;
      r_pick_v <= 1'b0;
      r_taken  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_addr   <= '0;
      r_bad    <= 1'b0;
    end else begin
      r_rp     <= w_rp_nxt;
      r_top    <= w_top_nxt;
      r_rz     <= (w_top_nxt == '0);
      r_taken  <= w_taken;
      r_pick_v <= 1'b0;
      // Set after clear so a simultaneous error is not lost.
      if (w_clr) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_udf_set) r_udf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_acc && op == OP_PICK) begin
            r_state <= S_PICK1;
            r_busy  <= 1'b1;
            r_addr  <= w_rpm1 - idx;
            r_bad   <= ({1'b0, idx} >= r_rp);
          end
        end
        S_PICK1: begin
          r_pick_o <= r_bad ? '0 : r_mem[r_addr];
          r_pick_v <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign r_o    = r_top;
  assign rz_o   = r_rz;
  assign rp_o   = r_rp;
  assign full   = w_full;
  assign empty  = w_empty;
  assign busy   = r_busy;
  assign pick_o = r_pick_o;
  assign pick_v = r_pick_v;
  assign taken  = r_taken;
  assign ovf    = r_ovf;
  assign udf    = r_udf;

endmodule

// File: tb/tb_ej32_rstack.sv
// Directed self-checking bench for ej32_rstack with DEPTH=4.
module tb_ej32_rstack;
  localparam int DSZ = 32;
  localparam int DEPTH = 4;
  localparam int SSZ = 2;

  logic           clk, rst, en;
  logic [2:0]     op;
  logic [DSZ-1:0] din;
  logic [SSZ-1:0] idx;
  logic [DSZ-1:0] r_o, pick_o;
  logic           rz_o, full, empty, busy, pick_v, taken, ovf, udf;
  logic [SSZ:0]   rp_o;

  int n_cmp = 0;
  int n_err = 0;

  ej32_rstack #(.DSZ(DSZ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .din(din), .idx(idx),
    .r_o(r_o), .rz_o(rz_o), .rp_o(rp_o), .full(full), .empty(empty),
    .busy(busy), .pick_o(pick_o), .pick_v(pick_v), .taken(taken),
    .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one op for a single rising edge, then returns to NOP at edge+1.
  task automatic do_op(input logic [2:0] o, input logic [DSZ-1:0] d, input logic [SSZ-1:0] i);
    op = o; din = d; idx = i;
    @(posedge clk); #1;
    op = 3'd0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; op = 3'd0; din = '0; idx = '0;
    #12 rst = 1'b0;
    chk("rst_rp", rp_o, 0);
    chk("rst_ro", r_o, 0);
    chk("rst_rz", rz_o, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pickv", pick_v, 0);
    chk("rst_picko", pick_o, 0);
    chk("rst_taken", taken, 0);
    chk("rst_errs", {ovf, udf}, 0);

    // Basic push/pop
    do_op(3'd1, 32'h11, 0);
    chk("push1_ro", r_o, 32'h11);
    chk("push1_rz", rz_o, 0);
    do_op(3'd1, 32'h22, 0);
    chk("push2_ro", r_o, 32'h22);
    chk("push2_rp", rp_o, 2);
    do_op(3'd2, 0, 0);
    chk("pop1_ro", r_o, 32'h11);
    chk("pop1_rp", rp_o, 1);
    do_op(3'd2, 0, 0);
    chk("pop2_ro", r_o, 0);
    chk("pop2_empty", empty, 1);
    chk("pop2_rz", rz_o, 1);

    // Enable low: op ignored
    en = 1'b0;
    do_op(3'd1, 32'h55, 0);
    en = 1'b1;
    chk("en0_rp", rp_o, 0);

    // Overflow and underflow
    do_op(3'd1, 1, 0);
    do_op(3'd1, 2, 0);
    do_op(3'd1, 3, 0);
    do_op(3'd1, 4, 0);
    chk("fill_full", full, 1);
    chk("fill_ovf", ovf, 0);
    do_op(3'd1, 5, 0);
    chk("ovf_flag", ovf, 1);
    chk("ovf_ro", r_o, 4);
    chk("ovf_rp", rp_o, 4);
    do_op(3'd6, 0, 0);
    chk("clr_ovf", ovf, 0);
    do_op(3'd2, 0, 0);
    chk("drain1_ro", r_o, 3);
    do_op(3'd2, 0, 0);
    chk("drain2_ro", r_o, 2);
    do_op(3'd2, 0, 0);
    chk("drain3_ro", r_o, 1);
    do_op(3'd2, 0, 0);
    chk("drain4_rp", rp_o, 0);
    chk("drain4_udf", udf, 0);
    do_op(3'd2, 0, 0);
    chk("udf_flag", udf, 1);
    chk("udf_rp", rp_o, 0);
    do_op(3'd6, 0, 0);
    chk("clr_udf", udf, 0);

    // DNEXT loop
    do_op(3'd1, 2, 0);
    do_op(3'd5, 0, 0);
    chk("dn1_taken", taken, 1);
    chk("dn1_ro", r_o, 1);
    do_op(3'd5, 0, 0);
    chk("dn2_taken", taken, 1);
    chk("dn2_ro", r_o, 0);
    chk("dn2_rz", rz_o, 1);
    chk("dn2_rp", rp_o, 1);
    do_op(3'd5, 0, 0);
    chk("dn3_taken", taken, 0);
    chk("dn3_rp", rp_o, 0);
    do_op(3'd0, 0, 0);
    chk("dn_idle_taken", taken, 0);
    do_op(3'd5, 0, 0);
    chk("dn_empty_udf", udf, 1);
    do_op(3'd6, 0, 0);
    // DNEXT writes the decremented value back to storage
    do_op(3'd1, 5, 0);
    do_op(3'd5, 0, 0);
    do_op(3'd1, 7, 0);
    do_op(3'd2, 0, 0);
    chk("dn_mem_ro", r_o, 4);
    do_op(3'd2, 0, 0);
    chk("dn_mem_rp", rp_o, 0);

    // PICK with push held during busy
    do_op(3'd1, 10, 0);
    do_op(3'd1, 20, 0);
    do_op(3'd1, 30, 0);
    op = 3'd4; idx = 2;
    @(posedge clk); #1;
    chk("pick_busy", busy, 1);
    chk("pick_v_early", pick_v, 0);
    op = 3'd1; din = 32'h77;
    @(posedge clk); #1;
    chk("pick_v", pick_v, 1);
    chk("pick_o", pick_o, 10);
    chk("pick_busy_clr", busy, 0);
    chk("pick_push_ign", rp_o, 3);
    op = 3'd0;
    @(posedge clk); #1;
    chk("pick_v_pulse", pick_v, 0);
    op = 3'd4; idx = 0;
    @(posedge clk); #1;
    op = 3'd0;
    @(posedge clk); #1;
    chk("pick0_o", pick_o, 30);

    // PICK out of range, then MOVE
    op = 3'd4; idx = 3;
    @(posedge clk); #1;
    op = 3'd0;
    chk("pickbad_udf", udf, 1);
    @(posedge clk); #1;
    chk("pickbad_v", pick_v, 1);
    chk("pickbad_o", pick_o, 0);
    do_op(3'd3, 32'h99, 0);
    chk("move_ro", r_o, 32'h99);
    chk("move_rp", rp_o, 3);
    do_op(3'd1, 32'hAA, 0);
    do_op(3'd2, 0, 0);
    chk("move_mem", r_o, 32'h99);
    do_op(3'd6, 0, 0);
    chk("clr_udf2", udf, 0);

    // Asynchronous reset mid-PICK
    op = 3'd4; idx = 1;
    @(posedge clk); #1;
    op = 3'd0;
    chk("arst_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rp", rp_o, 0);
    chk("arst_ro", r_o, 0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("arst_no_pickv", pick_v, 0);
    end
    do_op(3'd1, 32'h5A, 0);
    chk("post_rst_push", r_o, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
